very_half_sam_top: RTL and testbench

- 8-bit accumulator processor ("Very Half SAM") that fetches and executes one-byte instructions from external memory.
- Memory is reached over a separate 8-bit address bus, a bidirectional 8-bit data bus, and En/Rw/ALE strobes.
- A console interface allows pausing the processor and observing one internal register at a time.
- It is the top level of the CPU; the memory sits outside.

---
 rtl/very_half_sam_top.sv | 194 +++++++++++++++++++
 tb/tb_very_half_sam_top.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/very_half_sam_top.sv
// Very Half SAM: 8-bit accumulator CPU with a multiplexed external memory bus
// (separate address bus, bidirectional data bus, En/Rw/ALE strobes) and a
// console port for pausing and viewing one internal register at a time.
module very_half_sam_top (
  input  logic       clk,
  input  logic       rst,
  output logic       En,
  output logic       Rw,
  output logic [7:0] Address_Bus,
  inout  logic [7:0] Data_Bus,
  output logic       ALE,
  input  logic       pause,
  input  logic [1:0] regSelect,
  output logic [7:0] dispReg
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_R1,
    S_R2,
    S_R3,
    S_W1,
    S_W2,
    S_DECODE,
    S_HALT
  } state_t;

  // What the data byte of the current read is used for once it arrives.
  typedef enum logic [1:0] {
    RD_INSTR,
    RD_OPER,
    RD_PTR,
    RD_IND
  } rd_t;

  state_t     state;
  rd_t        rd_kind;
  logic [7:0] acc;
  logic [7:0] ireg;
  logic [7:0] pc;
  logic [7:0] iar;
  logic [7:0] dout;
  logic       drive;

  logic [3:0] opcode;
  logic [3:0] x;
  logic [7:0] addr_d;
  logic [7:0] disp;

  assign opcode = ireg[7:4];
  assign x      = ireg[3:0];
  assign addr_d = {4'h0, x};
  assign disp   = {{4{x[3]}}, x};

  // The CPU drives the data bus only in the data cycle of a write.
  assign Data_Bus = drive ? dout : 'z;

  // Console view of the selected register.
  always_comb begin
    dispReg = '0;
    unique case (regSelect)
      2'b00: dispReg = acc;
      2'b01: dispReg = ireg;
      2'b10: dispReg = pc;
      2'b11: dispReg = iar;
      default: dispReg = '0;
    endcase
  end

  // Instruction sequencer and bus engine; every bus strobe is registered so
  // each state's outputs are set on the edge that enters it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      rd_kind     <= RD_INSTR;
      acc         <= '0;
      ireg        <= '0;
      pc          <= '0;
      iar         <= '0;
      dout        <= '0;
      drive       <= 1'b0;
      En          <= 1'b0;
      Rw          <= 1'b1;
      ALE         <= 1'b0;
      Address_Bus <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          // Instruction boundary: pause holds the bus idle here.
          if (!pause) begin
            ALE         <= 1'b1;
            En          <= 1'b1;
            Rw          <= 1'b1;
            Address_Bus <= pc;
            rd_kind     <= RD_INSTR;
            state       <= S_R1;
          end
        end
        S_R1: begin
          ALE   <= 1'b0;
          state <= S_R2;
        end
        S_R2: begin
          En    <= 1'b0;
          state <= S_R3;
        end
        S_R3: begin
          state <= S_FETCH;
          unique case (rd_kind)
            RD_INSTR: begin
              ireg  <= Data_Bus;
              pc    <= pc + 8'd1;
              state <= S_DECODE;
            end
            RD_OPER: begin
              case (opcode)
                4'h5:    pc  <= Data_Bus;
                4'h7:    acc <= Data_Bus;
                4'hB:    acc <= acc + Data_Bus;
                4'hC:    acc <= acc & Data_Bus;
                default: ;
              endcase
            end
            RD_PTR: begin
              // Pointer fetched: chain straight into the indirect access.
              iar         <= Data_Bus;
              ALE         <= 1'b1;
              Address_Bus <= Data_Bus;
              if (opcode == 4'h8) begin
                En      <= 1'b1;
                Rw      <= 1'b1;
                rd_kind <= RD_IND;
                state   <= S_R1;
              end else begin
                En    <= 1'b0;
                Rw    <= 1'b0;
                dout  <= acc;
                state <= S_W1;
              end
            end
            RD_IND: acc <= Data_Bus;
            default: ;
          endcase
        end
        S_W1: begin
          ALE   <= 1'b0;
          En    <= 1'b1;
          drive <= 1'b1;
          state <= S_W2;
        end
        S_W2: begin
          En    <= 1'b0;
          Rw    <= 1'b1;
          drive <= 1'b0;
          state <= S_FETCH;
        end
        S_DECODE: begin
          state <= S_FETCH;
          case (opcode)
            4'h0: begin
              if (x == 4'h0)      state <= S_HALT;
              else if (x == 4'h1) acc   <= -acc;
            end
            4'h1: pc <= pc + disp;
            4'h2: if (acc == 8'h00)             pc <= pc + disp;
            4'h3: if (!acc[7] && acc != 8'h00)  pc <= pc + disp;
            4'h4: if (acc[7])                   pc <= pc + disp;
            4'h6: acc <= addr_d;
            4'h5, 4'h7, 4'hB, 4'hC, 4'h8, 4'hA: begin
              ALE         <= 1'b1;
              En          <= 1'b1;
              Rw          <= 1'b1;
              Address_Bus <= addr_d;
              rd_kind     <= (opcode == 4'h8 || opcode == 4'hA) ? RD_PTR : RD_OPER;
              state       <= S_R1;
            end
            4'h9: begin
              ALE         <= 1'b1;
              En          <= 1'b0;
              Rw          <= 1'b0;
              Address_Bus <= addr_d;
              dout        <= acc;
              state       <= S_W1;
            end
            default: ;
          endcase
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_very_half_sam_top.sv
// Directed bench for very_half_sam_top: small programs in a bus-level memory
// model, checking registers via the console port, bus address traces and
// write strobe ordering.
module tb_very_half_sam_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0;
  logic [1:0] regSelect = 2'b00;
  logic       En, Rw, ALE;
  logic [7:0] Address_Bus, dispReg;
  wire  [7:0] Data_Bus;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  very_half_sam_top dut (
    .clk        (clk),
    .rst        (rst),
    .En         (En),
    .Rw         (Rw),
    .Address_Bus(Address_Bus),
    .Data_Bus   (Data_Bus),
    .ALE        (ALE),
    .pause      (pause),
    .regSelect  (regSelect),
    .dispReg    (dispReg)
  );

  // Memory model: latches the address on ALE, drives read data in the cycles
  // after an enabled read, writes on an edge ending an enabled write.
  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic       load_req = 1'b0;
  logic [7:0] lat = 8'h00;
  logic       rd_drive = 1'b0;
  logic [7:0] alog [64];
  int         log_n = 0;
  int         wr_count = 0;
  int         wr_bad = 0;
  logic       prev_w1 = 1'b0;
  logic       prev_wr = 1'b0;
  logic [7:0] exp_q [$];

  assign Data_Bus = (rd_drive && Rw) ? mem[lat] : 'z;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] = img[i];
      log_n    = 0;
      wr_count = 0;
    end else begin
      if (ALE && log_n < 64) begin
        alog[log_n] = Address_Bus;
        log_n++;
      end
      if (En && !Rw) begin
        if (!prev_w1 || prev_wr || $isunknown(Data_Bus)) wr_bad++;
        mem[lat] = Data_Bus;
        wr_count++;
      end
    end
    prev_w1 = ALE && !En && !Rw;
    prev_wr = En && !Rw;
    rd_drive <= En && Rw;
    if (ALE) lat <= Address_Bus;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    regSelect = sel;
    #1;
    check(tag, dispReg, exp);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_len"}, 8'(log_n), 8'(exp_q.size()));
    foreach (exp_q[i]) if (i < log_n) check(tag, alog[i], exp_q[i]);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  // Holds reset for two cycles and loads the image; leaves rst asserted.
  task automatic reset_load();
    @(negedge clk);
    rst = 1'b1;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_halt(input string tag);
    int idle = 0;
    int n = 0;
    while (idle < 12 && n < 3000) begin
      @(negedge clk);
      n++;
      if (ALE || En) idle = 0;
      else idle++;
    end
    check({tag, "_halted"}, 8'(idle >= 12), 8'h01);
  endtask

  initial begin
    int n0;
    int n;
    logic found;

    // Main program with reset checks.
    clear_img();
    img[0] = 8'h63; img[1] = 8'h94; img[2] = 8'h01; img[3] = 8'h02;
    reset_load();
    check("rst_en", 8'(En), 8'h00);
    check("rst_ale", 8'(ALE), 8'h00);
    check("rst_rw", 8'(Rw), 8'h01);
    check("rst_bus_z", 8'(Data_Bus === 8'hzz), 8'h01);
    check_reg("rst_pc", 2'b10, 8'h00);
    check_reg("rst_acc", 2'b00, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_ale", 8'(ALE), 8'h01);
    check("first_addr", Address_Bus, 8'h00);
    check("first_en", 8'(En), 8'h01);
    run_halt("main");
    check_reg("main_acc", 2'b00, 8'hFD);
    check_reg("main_pc", 2'b10, 8'h06);
    check_reg("main_ireg", 2'b01, 8'h00);
    check("main_m4", mem[4], 8'h03);
    check("main_wrs", 8'(wr_count), 8'h01);
    exp_q = '{8'h00, 8'h01, 8'h04, 8'h02, 8'h03, 8'h04, 8'h05};
    check_log("main_log");
    n0 = log_n;
    repeat (20) @(negedge clk);
    check("halt_quiet", 8'(log_n - n0), 8'h00);

    // Unconditional branches.
    clear_img();
    img[0] = 8'h17; img[8] = 8'h17; img[16] = 8'h12;
    reset_load(); rst = 1'b0;
    run_halt("br");
    exp_q = '{8'h00, 8'h08, 8'h10, 8'h13};
    check_log("br_log");
    check_reg("br_pc", 2'b10, 8'h14);

    // Indirect branch through memory.
    clear_img();
    img[0] = 8'h53; img[3] = 8'h09;
    reset_load(); rst = 1'b0;
    run_halt("brind");
    exp_q = '{8'h00, 8'h03, 8'h09};
    check_log("brind_log");
    check_reg("brind_pc", 2'b10, 8'h0A);

    // brZero taken with ACC=0.
    clear_img();
    img[0] = 8'h60; img[1] = 8'h21;
    reset_load(); rst = 1'b0;
    run_halt("bz");
    exp_q = '{8'h00, 8'h01, 8'h03};
    check_log("bz_log");
    check_reg("bz_pc", 2'b10, 8'h04);

    // brZero not taken, brPos taken with ACC=2.
    clear_img();
    img[0] = 8'h62; img[1] = 8'h21; img[2] = 8'h31;
    reset_load(); rst = 1'b0;
    run_halt("bp");
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h04};
    check_log("bp_log");
    check_reg("bp_pc", 2'b10, 8'h05);
    check_reg("bp_acc", 2'b00, 8'h02);

    // brNeg taken, brPos not taken with ACC=0xF6.
    clear_img();
    img[0] = 8'h6A; img[1] = 8'h01; img[2] = 8'h41; img[4] = 8'h31;
    reset_load(); rst = 1'b0;
    run_halt("bn");
    exp_q = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h05};
    check_log("bn_log");
    check_reg("bn_pc", 2'b10, 8'h06);
    check_reg("bn_acc", 2'b00, 8'hF6);

    // iStore then iLoad through pointer M[2]=0x05 (also a no-op instruction).
    clear_img();
    img[0] = 8'h7E; img[1] = 8'hA2; img[2] = 8'h05; img[3] = 8'h60;
    img[4] = 8'h11; img[6] = 8'h82; img[14] = 8'h7A;
    reset_load(); rst = 1'b0;
    run_halt("ind");
    check_reg("ind_acc", 2'b00, 8'h7A);
    check_reg("ind_iar", 2'b11, 8'h05);
    check_reg("ind_pc", 2'b10, 8'h08);
    check("ind_m5", mem[5], 8'h7A);
    exp_q = '{8'h00, 8'h0E, 8'h01, 8'h02, 8'h05, 8'h02, 8'h03, 8'h04,
              8'h06, 8'h02, 8'h05, 8'h07};
    check_log("ind_log");

    // and then add (0xC0 & 0x9F = 0x80; 0x80 + 0x90 = 0x10).
    img[7] = 8'h7C; img[8] = 8'hCF; img[9] = 8'hBD;
    img[12] = 8'hC0; img[13] = 8'h90; img[15] = 8'h9F;
    reset_load(); rst = 1'b0;
    run_halt("alu");
    check_reg("alu_acc", 2'b00, 8'h10);
    check_reg("alu_pc", 2'b10, 8'h0B);

    // Pause raised during the operand read of a dLoad.
    clear_img();
    img[0] = 8'h7E; img[14] = 8'h7A;
    reset_load(); rst = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (ALE && Address_Bus == 8'h0E) found = 1'b1;
    end
    check("pause_oper_seen", 8'(found), 8'h01);
    pause = 1'b1;
    @(negedge clk);
    n0 = log_n;
    repeat (20) @(negedge clk);
    check("pause_quiet", 8'(log_n - n0), 8'h00);
    check_reg("pause_acc", 2'b00, 8'h7A);
    pause = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 10) begin
      @(negedge clk);
      n++;
      if (ALE) found = 1'b1;
    end
    check("resume_seen", 8'(found), 8'h01);
    check("resume_addr", Address_Bus, 8'h01);
    run_halt("pause");
    check_reg("pause_pc", 2'b10, 8'h02);

    // Reset during W1 of a dStore aborts the write.
    clear_img();
    img[0] = 8'h63; img[1] = 8'h94;
    reset_load(); rst = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 40) begin
      @(negedge clk);
      n++;
      if (ALE && !Rw) found = 1'b1;
    end
    check("abort_w1_seen", 8'(found), 8'h01);
    rst = 1'b1;
    @(negedge clk);
    check("abort_wrs", 8'(wr_count), 8'h00);
    check("abort_m4", mem[4], 8'h00);
    check("abort_en", 8'(En), 8'h00);
    check("abort_rw", 8'(Rw), 8'h01);
    rst = 1'b0;
    run_halt("abort");
    check("abort_m4_after", mem[4], 8'h03);
    check("abort_wrs_after", 8'(wr_count), 8'h01);
    check_reg("abort_pc", 2'b10, 8'h03);

    check("wr_protocol", 8'(wr_bad), 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
